// File: rtl/osc_pkg.sv
// Shared types for the oscillator burst scheduler.
// State encoding and per-requester configuration bundle.
package osc_pkg;

  localparam int OSC_CFG_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } osc_state_e;

  typedef struct packed {
    logic phase;
    logic duty;
    logic freq;
  } osc_cfg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection for the burst scheduler.
// With adv low the search starts at ptr itself, so a cleared pointer favours index 0.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            adv,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx
);

  int          start;
  int          j;
  logic        found;
  logic [IW-1:0] idx;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    j       = 0;
    start   = int'(ptr) + (adv ? 1 : 0);
    if (start >= NREQ) start = start - NREQ;
    for (int i = 0; i < NREQ; i++) begin
      j = start + i;
      if (j >= NREQ) j = j - NREQ;
      idx = IW'(j);
      if (!found && req[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/osc_burst_scheduler.sv
// Shares one oscillator among NREQ requesters, one burst at a time.
// Outputs are registered from the next-state decode so they align with the state.
module osc_burst_scheduler
  import osc_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int LEN_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  input  logic [NREQ*3-1:0]      req_cfg,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   osc_rst,
  output logic                   osc_en,
  output logic                   osc_freq_sel,
  output logic                   osc_duty_sel,
  output logic                   osc_phase_sel,
  output logic                   busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  osc_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             osc_rst_q, osc_rst_d;
  logic             osc_en_q, osc_en_d;
  logic             busy_q, busy_d;
  osc_cfg_t         cfg_q, cfg_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       stl_q, stl_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             ptr_vld_q, ptr_vld_d;

  logic [NREQ-1:0]      win_oh;
  logic [IW-1:0]        win_idx;
  logic [OSC_CFG_W-1:0] sel_cfg;
  logic [LEN_W-1:0]     sel_len;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .adv     (ptr_vld_q),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  always_comb begin
    sel_cfg = '0;
    sel_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        sel_cfg = sel_cfg | req_cfg[i*OSC_CFG_W +: OSC_CFG_W];
        sel_len = sel_len | req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cfg_d     = cfg_q;
    len_d     = len_q;
    stl_d     = stl_q;
    ptr_d     = ptr_q;
    ptr_vld_d = ptr_vld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_CONFIG;
          gnt_d     = win_oh;
          ptr_d     = win_idx;
          ptr_vld_d = 1'b1;
          cfg_d     = osc_cfg_t'(sel_cfg);
          len_d     = sel_len;
        end
      end
      ST_CONFIG: begin
        state_d = ST_SETTLE;
        stl_d   = 4'(SETTLE);
      end
      ST_SETTLE: begin
        stl_d = stl_q - 4'd1;
        if (stl_q == 4'd1) begin
          state_d = (len_q == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        len_d = len_q - LEN_W'(1);
        if (len_q == LEN_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    osc_en_d  = (state_d == ST_RUN);
    osc_rst_d = (state_d == ST_CONFIG);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE) ? gnt_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      osc_rst_q <= 1'b0;
      osc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      cfg_q     <= '0;
      len_q     <= '0;
      stl_q     <= '0;
      ptr_q     <= '0;
      ptr_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      osc_rst_q <= osc_rst_d;
      osc_en_q  <= osc_en_d;
      busy_q    <= busy_d;
      cfg_q     <= cfg_d;
      len_q     <= len_d;
      stl_q     <= stl_d;
      ptr_q     <= ptr_d;
      ptr_vld_q <= ptr_vld_d;
    end
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign osc_rst       = osc_rst_q;
  assign osc_en        = osc_en_q;
  assign busy          = busy_q;
  assign osc_freq_sel  = cfg_q.freq;
  assign osc_duty_sel  = cfg_q.duty;
  assign osc_phase_sel = cfg_q.phase;

endmodule

// File: tb/tb_osc_burst_scheduler.sv
// Scoreboard bench for osc_burst_scheduler.
// Expected bursts are queued at stimulus time and retired on each done pulse.
module tb_osc_burst_scheduler;

  localparam int NREQ   = 4;
  localparam int LEN_W  = 8;
  localparam int SETTLE = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ*3-1:0]     req_cfg;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  osc_rst;
  logic                  osc_en;
  logic                  osc_freq_sel;
  logic                  osc_duty_sel;
  logic                  osc_phase_sel;
  logic                  busy;

  osc_burst_scheduler #(
    .NREQ   (NREQ),
    .LEN_W  (LEN_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_len       (req_len),
    .req_cfg       (req_cfg),
    .gnt           (gnt),
    .done          (done),
    .osc_rst       (osc_rst),
    .osc_en        (osc_en),
    .osc_freq_sel  (osc_freq_sel),
    .osc_duty_sel  (osc_duty_sel),
    .osc_phase_sel (osc_phase_sel),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct {
    int idx;
    int len;
    int cfg;
    int gap;
  } exp_t;

  exp_t sb[$];

  task automatic expect_burst(input int idx, input int len,
                              input int cfg, input int gap);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.cfg = cfg;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input int len, input int cfg);
    req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
    req_cfg[i*3 +: 3]         = 3'(cfg);
  endtask

  bit in_b = 1'b0;
  bit cfg_chg;
  int b_cfg, n_en, n_rst, n_busy, gap;
  int idle_run  = 0;
  int done_seen = 0;
  int aborted   = 0;

  wire [2:0] cur_cfg = {osc_phase_sel, osc_duty_sel, osc_freq_sel};

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("gnt_onehot0", int'($onehot0(gnt)), 1);
      chk("done_in_gnt", int'(done & ~gnt), 0);
      if (!in_b && gnt == '0) chk("idle_quiet", int'({osc_en, osc_rst, done}), 0);
    end
    if (!in_b && gnt != '0) begin
      in_b    = 1'b1;
      b_cfg   = int'(cur_cfg);
      n_en    = 0;
      n_rst   = 0;
      n_busy  = 0;
      cfg_chg = 1'b0;
      gap     = idle_run;
    end
    if (in_b) begin
      n_en   += int'(osc_en);
      n_rst  += int'(osc_rst);
      n_busy += int'(busy);
      if (int'(cur_cfg) != b_cfg) cfg_chg = 1'b1;
      if (done != '0) begin
        in_b = 1'b0;
        done_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          e = sb.pop_front();
          chk("done_idx", int'(done), 1 << e.idx);
          chk("gnt_idx", int'(gnt), 1 << e.idx);
          chk("en_cycles", n_en, e.len);
          chk("rst_cycles", n_rst, 1);
          chk("busy_cycles", n_busy, SETTLE + e.len + 2);
          chk("cfg", b_cfg, e.cfg);
          chk("cfg_frozen", int'(cfg_chg), 0);
          if (e.gap >= 0) chk("idle_gap", gap, e.gap);
        end
      end else if (gnt == '0) begin
        in_b = 1'b0;
        aborted++;
      end
    end
    idle_run = busy ? 0 : idle_run + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_seen < target && k < budget) begin
      tick();
      k++;
    end
    chk("wait_done", int'(done_seen >= target), 1);
  endtask

  task automatic wait_en(input int budget);
    int k = 0;
    while (osc_en !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk("wait_en", int'(osc_en), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy !== 1'b0 || gnt !== '0) && k < budget) begin
      tick();
      k++;
    end
    chk("wait_idle", int'(busy), 0);
  endtask

  int base;

  initial begin
    rst     = 1'b1;
    req     = '0;
    req_len = '0;
    req_cfg = '0;
    repeat (3) tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_en", int'(osc_en), 0);
    chk("rst_osc_rst", int'(osc_rst), 0);
    chk("rst_cfg", int'(cur_cfg), 0);
    rst = 1'b0;
    tick();

    // single request, grant one cycle after req
    set_req(0, 5, 3'b101);
    expect_burst(0, 5, 3'b101, -1);
    req = 4'b0001;
    tick();
    chk("t1_gnt_lat", int'(gnt), 1);
    chk("t1_osc_rst", int'(osc_rst), 1);
    req = '0;
    wait_idle(50);

    // round robin from reset: 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1, i + 1);
    expect_burst(0, 1, 1, -1);
    expect_burst(1, 1, 2, 1);
    expect_burst(2, 1, 3, 1);
    expect_burst(3, 1, 4, 1);
    expect_burst(0, 1, 1, 1);
    base = done_seen;
    req  = 4'b1111;
    wait_done(base + 5, 200);
    req = '0;
    wait_idle(50);

    // zero length burst
    set_req(2, 0, 6);
    expect_burst(2, 0, 6, -1);
    req = 4'b0100;
    tick();
    req = '0;
    wait_idle(50);

    // config freeze while running
    set_req(1, 10, 3);
    expect_burst(1, 10, 3, -1);
    req = 4'b0010;
    wait_en(50);
    for (int i = 0; i < NREQ; i++) set_req(i, 3, 4);
    req = '0;
    wait_idle(100);

    // reset in the third RUN cycle
    set_req(2, 8, 7);
    req = 4'b0100;
    wait_en(50);
    tick();
    tick();
    req = '0;
    rst = 1'b1;
    tick();
    chk("t5_en", int'(osc_en), 0);
    chk("t5_gnt", int'(gnt), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_abort", aborted, 1);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1, i + 1);
    expect_burst(0, 1, 1, -1);
    req = 4'b1111;
    tick();
    chk("t5_regrant", int'(gnt), 1);
    req = '0;
    wait_idle(50);

    // wrap after index 3
    set_req(3, 2, 5);
    expect_burst(3, 2, 5, -1);
    req = 4'b1000;
    tick();
    req = '0;
    wait_idle(50);
    set_req(0, 2, 1);
    expect_burst(0, 2, 1, -1);
    expect_burst(3, 2, 5, 1);
    base = done_seen;
    req  = 4'b1001;
    wait_done(base + 2, 100);
    req = '0;
    wait_idle(50);

    chk("sb_drained", sb.size(), 0);
    chk("abort_total", aborted, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/osc_burst_scheduler.md
OSC_BURST_SCHEDULER -- requirements
Module: osc_burst_scheduler

Interface
REQ-001 Parameters SHALL be:
- NREQ, default 4: number of requesters.
- LEN_W, default 8: width of the burst-length field.
- SETTLE, default 2: number of cycles between configuration and enable; legal values are 1..15.

REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- req, in, NREQ: per-requester burst request level.
- req_len, in, NREQ*LEN_W: burst length in cycles; requester i occupies slice [i*LEN_W +: LEN_W].
- req_cfg, in, NREQ*3: per-requester configuration {phase_shift_sel, duty_cycle_sel, freq_select}; requester i occupies slice [i*3 +: 3].
- gnt, out, NREQ: one-hot grant, held for the whole burst.
- done, out, NREQ: one-cycle completion pulse to the granted requester.
- osc_rst, out, 1: oscillator reset strobe.
- osc_en, out, 1: oscillator enable.
- osc_freq_sel, out, 1: oscillator frequency select.
- osc_duty_sel, out, 1: oscillator duty-cycle select.
- osc_phase_sel, out, 1: oscillator phase-shift select.
- busy, out, 1: high in every state except IDLE.

Function
REQ-003 The block SHALL share one oscillator among NREQ requesters, one non-preemptive burst at a time.

REQ-004 The FSM states SHALL be IDLE, CONFIG, SETTLE, RUN, DONE.

REQ-005 IDLE with req!=0 SHALL go to CONFIG on the next edge; IDLE with req==0 SHALL stay in IDLE.

REQ-006 On the IDLE->CONFIG edge the block SHALL:
- choose the winner round-robin, starting from the index after the last winner;
- register gnt for the winner;
- latch the winner's req_cfg into the osc_*_sel outputs;
- latch the winner's req_len into the burst counter.

REQ-007 In CONFIG, osc_rst SHALL be 1 for exactly one cycle, and CONFIG SHALL always go to SETTLE.

REQ-008 SETTLE SHALL last exactly SETTLE cycles, counted down by a settle counter, and then go to RUN; if the latched length is 0 it SHALL go to DONE instead.

REQ-009 RUN SHALL hold osc_en=1 for exactly the latched length in cycles; the counter decrements each cycle and the state moves to DONE on the cycle the counter reaches 1.

REQ-010 DONE SHALL last one cycle, with done[winner]=1 and gnt still asserted; the next edge SHALL clear gnt and return to IDLE.

REQ-011 Grant latency SHALL be 1 cycle from req sampled in IDLE to gnt high.

REQ-012 Minimum burst-to-burst turnaround SHALL be 1 IDLE cycle.

REQ-013 Deasserting req[winner] mid-burst SHALL NOT shorten or abort the burst.

REQ-014 Changes to req_cfg or req_len after latching SHALL be ignored until the next grant.

REQ-015 The round-robin pointer SHALL update only on the grant edge, and only to the winner index.

REQ-016 The round-robin search SHALL wrap from index NREQ-1 to index 0.

REQ-017 A lone requester SHALL be re-granted back-to-back, with one IDLE cycle between bursts.

REQ-018 osc_en SHALL be 0 in every state except RUN, and osc_rst SHALL be 0 in every state except CONFIG.

REQ-019 gnt SHALL always be one-hot or zero, and done SHALL be a subset of gnt.

REQ-020 All outputs SHALL be registered.

Reset
REQ-021 When rst=1 at a clock edge, the block SHALL:
- force state to IDLE;
- clear gnt, done, osc_en, osc_rst, all osc_*_sel outputs, busy, both counters, and the round-robin pointer (pointer cleared so index 0 has first priority).

REQ-022 Reset asserted mid-burst SHALL abort the burst with no done pulse, and osc_en SHALL be 0 on the cycle after the reset edge.

REQ-023 With rst=0, the first grant after reset SHALL follow the same rules as any other grant, with index 0 at highest priority.

Structure
REQ-024 Package osc_pkg SHALL hold:
- the state enum (5 states, 3 bits);
- the osc_cfg_t typedef {phase, duty, freq};
- the constant OSC_CFG_W = 3.

REQ-025 Round-robin selection SHALL be a sub-module, rr_arbiter, parameterised by NREQ; it takes req, the pointer and an advance strobe, and outputs the one-hot winner and the winner index.

REQ-026 The FSM and both counters SHALL live in osc_burst_scheduler.

Verification
REQ-027 Single request: req=0001, len=5, cfg=3'b101, SETTLE=2 → gnt=0001 at cycle+1, osc_rst for 1 cycle, osc_en for 5 cycles, done[0] pulse, busy for 9 cycles total.

REQ-028 Round-robin: req=1111 held, len=1 each → grant order 0,1,2,3,0, with one IDLE cycle between bursts.

REQ-029 Zero length: req=0100, len=0 → CONFIG, then SETTLE, then DONE; osc_en never asserts; done[2] pulses.

REQ-030 Config freeze: change req_cfg and drop req[1] during RUN of a len=10 burst → osc_*_sel unchanged, osc_en held for 10 cycles, done[1] pulses.

REQ-031 Reset mid-RUN: rst at RUN cycle 3 → next cycle osc_en=0, gnt=0, no done pulse, and the next grant goes to index 0.

REQ-032 Wrap: the last winner is index 3 and req=1001 → index 0 is granted next, then index 3.
